// File: rtl/cpu_control_fsm_if.sv
// Control/status bundle between cpu_control_fsm (master) and the simple_cpu
// datapath, instruction decoder and memories (slave).
interface cpu_control_fsm_if #(
    parameter int CNT_W = 32
);
    logic             imem_req;
    logic             imem_ready;
    logic             ir_load;
    logic             is_alu_reg;
    logic             is_alu_imm;
    logic             is_load;
    logic             is_store;
    logic             is_branch;
    logic             is_jal;
    logic             is_jalr;
    logic             is_lui;
    logic             is_auipc;
    logic             is_system;
    logic             reg_write;
    logic             branch_taken;
    logic             alu_en;
    logic             dmem_req;
    logic             dmem_we;
    logic             dmem_ready;
    logic             rf_we;
    logic [1:0]       wb_sel;
    logic             pc_write;
    logic [1:0]       pc_sel;
    logic             halted;
    logic             trap;
    logic [1:0]       trap_cause;
    logic [CNT_W-1:0] instret;

    modport master (
        output imem_req, ir_load, alu_en, dmem_req, dmem_we, rf_we, wb_sel,
               pc_write, pc_sel, halted, trap, trap_cause, instret,
        input  imem_ready, is_alu_reg, is_alu_imm, is_load, is_store, is_branch,
               is_jal, is_jalr, is_lui, is_auipc, is_system, reg_write,
               branch_taken, dmem_ready
    );

    modport slave (
        input  imem_req, ir_load, alu_en, dmem_req, dmem_we, rf_we, wb_sel,
               pc_write, pc_sel, halted, trap, trap_cause, instret,
        output imem_ready, is_alu_reg, is_alu_imm, is_load, is_store, is_branch,
               is_jal, is_jalr, is_lui, is_auipc, is_system, reg_write,
               branch_taken, dmem_ready
    );
endinterface

// File: rtl/cpu_control_fsm.sv
// Multi-cycle control sequencer for simple_cpu: fetch, one-shot decode sampling,
// ALU / data memory / writeback / PC sequencing, with halt, illegal and timeout traps.
//
//  state  | meaning
//  FETCH  | imem_req high, wait for imem_ready (bounded by wait counter)
//  DECODE | latch decoder flags, pick HALT / TRAP / EXEC
//  EXEC   | alu_en high, latch branch_taken
//  MEM    | dmem_req high (dmem_we for stores), wait for dmem_ready
//  WB     | pc_write, register writeback, instret increment
//  HALT   | SYSTEM retired, absorbing until rst
//  TRAP   | illegal opcode or timeout, absorbing until rst
module cpu_control_fsm #(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int CNT_W          = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    cpu_control_fsm_if.master bus
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_TRAP
    } state_e;

    typedef enum logic [3:0] {
        C_NONE, C_SYSTEM, C_JAL, C_JALR, C_BRANCH, C_LOAD, C_STORE,
        C_LUI, C_AUIPC, C_ALU_IMM, C_ALU_REG
    } class_e;

    localparam int F_ALU_REG = 0;
    localparam int F_ALU_IMM = 1;
    localparam int F_LOAD    = 2;
    localparam int F_STORE   = 3;
    localparam int F_BRANCH  = 4;
    localparam int F_JAL     = 5;
    localparam int F_JALR    = 6;
    localparam int F_LUI     = 7;
    localparam int F_AUIPC   = 8;
    localparam int F_SYSTEM  = 9;
    localparam int F_REGW    = 10;

    localparam int              WAIT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    state_e             state_q, state_d;
    logic [10:0]        flags_q, flags_d, flags_in;
    logic               taken_q, taken_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0]   instret_q, instret_d;
    logic [1:0]         cause_q, cause_d;
    class_e             cls_q;
    logic               rf_we_d;
    logic [1:0]         wb_sel_d, pc_sel_d;

    logic               imem_req_q, alu_en_q, dmem_req_q, dmem_we_q;
    logic               rf_we_q, pc_write_q, halted_q, trap_q;
    logic [1:0]         wb_sel_q, pc_sel_q;

    // Several flags may be set at once; the highest-priority class wins.
    function automatic class_e resolve(input logic [10:0] f);
        if (f[F_SYSTEM])       return C_SYSTEM;
        else if (f[F_JAL])     return C_JAL;
        else if (f[F_JALR])    return C_JALR;
        else if (f[F_BRANCH])  return C_BRANCH;
        else if (f[F_LOAD])    return C_LOAD;
        else if (f[F_STORE])   return C_STORE;
        else if (f[F_LUI])     return C_LUI;
        else if (f[F_AUIPC])   return C_AUIPC;
        else if (f[F_ALU_IMM]) return C_ALU_IMM;
        else if (f[F_ALU_REG]) return C_ALU_REG;
        else                   return C_NONE;
    endfunction

    assign flags_in = {bus.reg_write, bus.is_system, bus.is_auipc, bus.is_lui,
                       bus.is_jalr, bus.is_jal, bus.is_branch, bus.is_store,
                       bus.is_load, bus.is_alu_imm, bus.is_alu_reg};
    assign cls_q    = resolve(flags_q);

    always_comb begin
        state_d   = state_q;
        flags_d   = flags_q;
        taken_d   = taken_q;
        wait_d    = wait_q;
        instret_d = instret_q;
        cause_d   = cause_q;
        case (state_q)
            S_FETCH: begin
                if (bus.imem_ready) begin
                    state_d = S_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_TRAP;
                    cause_d = 2'd2;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_DECODE: begin
                flags_d = flags_in;
                if (resolve(flags_in) == C_SYSTEM) begin
                    state_d = S_HALT;
                end else if (resolve(flags_in) == C_NONE) begin
                    state_d = S_TRAP;
                    cause_d = 2'd1;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                taken_d = bus.branch_taken;
                if (cls_q == C_LOAD || cls_q == C_STORE) begin
                    state_d = S_MEM;
                    wait_d  = '0;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (bus.dmem_ready) begin
                    state_d = S_WB;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_TRAP;
                    cause_d = 2'd3;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_WB: begin
                state_d   = S_FETCH;
                wait_d    = '0;
                instret_d = instret_q + 1'b1;
            end
            S_HALT, S_TRAP: state_d = state_q;
            default:        state_d = S_FETCH;
        endcase

        rf_we_d  = flags_q[F_REGW] && cls_q != C_STORE && cls_q != C_BRANCH;
        wb_sel_d = 2'd0;
        pc_sel_d = 2'd0;
        case (cls_q)
            C_LOAD:   wb_sel_d = 2'd1;
            C_LUI:    wb_sel_d = 2'd3;
            C_JAL:    begin wb_sel_d = 2'd2; pc_sel_d = 2'd1; end
            C_JALR:   begin wb_sel_d = 2'd2; pc_sel_d = 2'd2; end
            C_BRANCH: pc_sel_d = taken_d ? 2'd1 : 2'd0;
            default:  ;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_FETCH;
            flags_q    <= '0;
            taken_q    <= 1'b0;
            wait_q     <= '0;
            instret_q  <= '0;
            cause_q    <= 2'd0;
            imem_req_q <= 1'b1;
            alu_en_q   <= 1'b0;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            rf_we_q    <= 1'b0;
            pc_write_q <= 1'b0;
            wb_sel_q   <= 2'd0;
            pc_sel_q   <= 2'd0;
            halted_q   <= 1'b0;
            trap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            flags_q    <= flags_d;
            taken_q    <= taken_d;
            wait_q     <= wait_d;
            instret_q  <= instret_d;
            cause_q    <= cause_d;
            imem_req_q <= (state_d == S_FETCH);
            alu_en_q   <= (state_d == S_EXEC);
            dmem_req_q <= (state_d == S_MEM);
            dmem_we_q  <= (state_d == S_MEM) && (cls_q == C_STORE);
            pc_write_q <= (state_d == S_WB);
            rf_we_q    <= (state_d == S_WB) && rf_we_d;
            wb_sel_q   <= (state_d == S_WB) ? wb_sel_d : 2'd0;
            pc_sel_q   <= (state_d == S_WB) ? pc_sel_d : 2'd0;
            halted_q   <= (state_d == S_HALT);
            trap_q     <= (state_d == S_TRAP);
        end
    end

    assign bus.imem_req   = imem_req_q;
    assign bus.ir_load    = imem_req_q & bus.imem_ready;
    assign bus.alu_en     = alu_en_q;
    assign bus.dmem_req   = dmem_req_q;
    assign bus.dmem_we    = dmem_we_q;
    assign bus.rf_we      = rf_we_q;
    assign bus.wb_sel     = wb_sel_q;
    assign bus.pc_write   = pc_write_q;
    assign bus.pc_sel     = pc_sel_q;
    assign bus.halted     = halted_q;
    assign bus.trap       = trap_q;
    assign bus.trap_cause = cause_q;
    assign bus.instret    = instret_q;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Scoreboard bench for cpu_control_fsm: a driver issues instructions and pushes the
// expected writeback into a queue; an independent monitor checks every retirement.
`timescale 1ns/1ps
module tb_cpu_control_fsm;

    localparam int TO = 15;
    localparam int I_REG = 0, I_IMM = 1, I_LD = 2, I_ST = 3, I_BR = 4, I_JAL = 5;
    localparam int I_JALR = 6, I_LUI = 7, I_AUIPC = 8, I_SYS = 9, I_RW = 10;

    typedef struct {
        bit       mem;
        bit       we;
        bit       rf_we;
        bit [1:0] wb_sel;
        bit [1:0] pc_sel;
        int       mdly;
        int       instret;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cpu_control_fsm_if #(.CNT_W(32)) bus();
    cpu_control_fsm #(.TIMEOUT_CYCLES(TO), .CNT_W(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   retired  = 0;
    bit   mon_en   = 1'b0;
    int   prio[10]   = '{I_SYS, I_JAL, I_JALR, I_BR, I_LD, I_ST, I_LUI, I_AUIPC, I_IMM, I_REG};
    int   nonsys[9]  = '{I_REG, I_IMM, I_LD, I_ST, I_BR, I_JAL, I_JALR, I_LUI, I_AUIPC};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: bound expired, got no event expected event", name);
    endtask

    function automatic bit [10:0] fb(input int i);
        return 11'(1) << i;
    endfunction

    // Reference: highest-priority class decides memory use and writeback/PC selection.
    function automatic exp_t model(input bit [10:0] fl, input bit taken, input int mdly, input int cnt);
        exp_t e;
        int   cls;
        cls = -1;
        foreach (prio[k]) if (cls < 0 && fl[prio[k]]) cls = prio[k];
        e = '{mem: 0, we: 0, rf_we: 0, wb_sel: 0, pc_sel: 0, mdly: mdly, instret: cnt};
        e.rf_we = fl[I_RW] && cls != I_ST && cls != I_BR;
        case (cls)
            I_LD:    begin e.mem = 1; e.wb_sel = 1; end
            I_ST:    begin e.mem = 1; e.we = 1; end
            I_BR:    e.pc_sel = taken ? 2'd1 : 2'd0;
            I_JAL:   begin e.wb_sel = 2; e.pc_sel = 1; end
            I_JALR:  begin e.wb_sel = 2; e.pc_sel = 2; end
            I_LUI:   e.wb_sel = 3;
            default: ;
        endcase
        return e;
    endfunction

    task automatic apply_flags(input bit [10:0] fl);
        bus.is_alu_reg = fl[I_REG];
        bus.is_alu_imm = fl[I_IMM];
        bus.is_load    = fl[I_LD];
        bus.is_store   = fl[I_ST];
        bus.is_branch  = fl[I_BR];
        bus.is_jal     = fl[I_JAL];
        bus.is_jalr    = fl[I_JALR];
        bus.is_lui     = fl[I_LUI];
        bus.is_auipc   = fl[I_AUIPC];
        bus.is_system  = fl[I_SYS];
        bus.reg_write  = fl[I_RW];
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        rst = 1'b1;
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        retired = 0;
    endtask

    // Flags are scrambled once the instruction is past DECODE: the DUT must hold its copy.
    task automatic drive_instr(input bit [10:0] fl, input bit taken, input int fdly,
                               input int mdly, input bit mem);
        int n;
        n = 0;
        while (bus.imem_req !== 1'b1) begin
            @(negedge clk);
            n++;
            if (n > 50) begin bound_fail("imem_req_wait"); return; end
        end
        for (int i = 0; i <= fdly; i++) begin
            bus.imem_ready = (i == fdly);
            if (i == fdly) begin
                apply_flags(fl);
                bus.branch_taken = taken;
            end
            @(negedge clk);
        end
        bus.imem_ready = 1'b0;
        @(negedge clk);
        apply_flags(11'($urandom));
        if (!mem) return;
        n = 0;
        while (bus.dmem_req !== 1'b1) begin
            @(negedge clk);
            n++;
            if (n > 50) begin bound_fail("dmem_req_wait"); return; end
        end
        for (int i = 0; i <= mdly; i++) begin
            bus.dmem_ready = (i == mdly);
            @(negedge clk);
        end
        bus.dmem_ready = 1'b0;
    endtask

    task automatic issue(input bit [10:0] fl, input bit taken, input int fdly, input int mdly);
        exp_t e;
        e = model(fl, taken, mdly, retired);
        exp_q.push_back(e);
        retired++;
        drive_instr(fl, taken, fdly, mdly, e.mem);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) bound_fail("drain_scoreboard");
    endtask

    initial begin : monitor
        int   cyc, t_load, dm_cyc, alu_cyc;
        bit   we_seen;
        exp_t e;
        cyc = 0; t_load = 0; dm_cyc = 0; alu_cyc = 0; we_seen = 0;
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            if (!mon_en) begin
                dm_cyc = 0; alu_cyc = 0; we_seen = 0;
                continue;
            end
            if (bus.imem_ready === 1'b1) chk("ir_load", 32'(bus.ir_load), 32'(bus.imem_req));
            if (bus.ir_load === 1'b1) t_load = cyc;
            if (bus.dmem_req === 1'b1) begin
                dm_cyc++;
                we_seen |= bus.dmem_we;
            end
            if (bus.alu_en === 1'b1) alu_cyc++;
            if (bus.pc_write === 1'b1) begin
                if (exp_q.size() == 0) begin
                    bound_fail("unexpected_retire");
                end else begin
                    e = exp_q.pop_front();
                    chk("rf_we",     32'(bus.rf_we),  32'(e.rf_we));
                    chk("wb_sel",    32'(bus.wb_sel), 32'(e.wb_sel));
                    chk("pc_sel",    32'(bus.pc_sel), 32'(e.pc_sel));
                    chk("instret",   bus.instret,     e.instret);
                    chk("latency",   cyc - t_load,    e.mem ? 4 + e.mdly : 3);
                    chk("dmem_cyc",  dm_cyc,          e.mem ? e.mdly + 1 : 0);
                    chk("dmem_we",   32'(we_seen),    32'(e.we));
                    chk("alu_cyc",   alu_cyc,         1);
                end
                dm_cyc = 0; alu_cyc = 0; we_seen = 0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no end of test expected end before 500us");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        bit [10:0] fl;
        int        n;
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        bus.branch_taken = 1'b0;
        apply_flags('0);

        do_reset();
        chk("rst_imem_req", 32'(bus.imem_req),   1);
        chk("rst_dmem_req", 32'(bus.dmem_req),   0);
        chk("rst_pc_write", 32'(bus.pc_write),   0);
        chk("rst_halted",   32'(bus.halted),     0);
        chk("rst_trap",     32'(bus.trap),       0);
        chk("rst_cause",    32'(bus.trap_cause), 0);
        chk("rst_instret",  bus.instret,         0);

        mon_en = 1'b1;
        issue(fb(I_IMM) | fb(I_RW), 1'b0, 0, 0);
        issue(fb(I_LD)  | fb(I_RW), 1'b0, 1, 3);
        issue(fb(I_ST)  | fb(I_RW), 1'b0, 0, 0);
        issue(fb(I_BR)  | fb(I_RW), 1'b1, 0, 0);
        issue(fb(I_BR),             1'b0, 2, 0);
        issue(fb(I_JALR)| fb(I_RW), 1'b1, 0, 0);
        issue(fb(I_JAL) | fb(I_RW), 1'b0, 0, 0);
        issue(fb(I_LUI) | fb(I_RW), 1'b0, 0, 0);
        issue(fb(I_AUIPC)|fb(I_RW), 1'b0, 0, 0);
        issue(fb(I_REG) | fb(I_RW), 1'b0, 0, 0);
        issue(fb(I_LD)  | fb(I_RW), 1'b0, TO - 1, TO - 1);
        issue(fb(I_JAL) | fb(I_LD) | fb(I_RW), 1'b0, 0, 0);
        issue(fb(I_LUI) | fb(I_ST) | fb(I_RW), 1'b0, 0, 2);
        repeat (60) begin
            fl = fb(nonsys[$urandom_range(0, 8)]);
            if ($urandom_range(0, 7) == 0) fl |= fb(nonsys[$urandom_range(0, 8)]);
            fl[I_RW] = 1'($urandom);
            issue(fl, 1'($urandom),
                  ($urandom_range(0, 9) == 0) ? $urandom_range(0, TO - 1) : $urandom_range(0, 2),
                  ($urandom_range(0, 9) == 0) ? $urandom_range(0, TO - 1) : $urandom_range(0, 2));
        end
        drain();
        chk("instret_total", bus.instret, retired);
        chk("no_trap_after_run", 32'(bus.trap), 0);

        // Reset while a load is waiting in MEM.
        mon_en = 1'b0;
        apply_flags(fb(I_LD) | fb(I_RW));
        bus.imem_ready = 1'b1;
        @(negedge clk);
        bus.imem_ready = 1'b0;
        n = 0;
        while (bus.dmem_req !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        if (bus.dmem_req !== 1'b1) bound_fail("dmem_req_before_reset");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmem_dmem_req", 32'(bus.dmem_req), 0);
        chk("rstmem_imem_req", 32'(bus.imem_req), 1);
        chk("rstmem_instret",  bus.instret,       0);
        chk("rstmem_pc_write", 32'(bus.pc_write), 0);
        rst = 1'b0;

        // Fetch timeout: 14 idle waits survive, the 15th traps.
        do_reset();
        repeat (TO - 1) @(negedge clk);
        chk("ito_pre_trap",     32'(bus.trap),     0);
        chk("ito_pre_imem_req", 32'(bus.imem_req), 1);
        @(negedge clk);
        chk("ito_trap",     32'(bus.trap),       1);
        chk("ito_cause",    32'(bus.trap_cause), 2);
        chk("ito_imem_req", 32'(bus.imem_req),   0);
        bus.imem_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("ito_sticky",   32'(bus.trap),       1);
        chk("ito_no_fetch", 32'(bus.ir_load),    0);
        bus.imem_ready = 1'b0;

        // Ready arriving on the 15th wait clock wins over the timeout.
        do_reset();
        mon_en = 1'b1;
        issue(fb(I_IMM) | fb(I_RW), 1'b0, TO - 1, 0);
        drain();
        chk("ready_at_limit_trap", 32'(bus.trap), 0);

        // Data memory timeout.
        do_reset();
        drive_instr(fb(I_LD) | fb(I_RW), 1'b0, 0, TO, 1'b1);
        chk("dto_trap",     32'(bus.trap),       1);
        chk("dto_cause",    32'(bus.trap_cause), 3);
        chk("dto_dmem_req", 32'(bus.dmem_req),   0);

        // Illegal opcode, then reset clears it.
        do_reset();
        drive_instr(fb(I_RW), 1'b0, 0, 0, 1'b0);
        chk("ill_trap",   32'(bus.trap),       1);
        chk("ill_cause",  32'(bus.trap_cause), 1);
        chk("ill_halted", 32'(bus.halted),     0);
        repeat (5) @(negedge clk);
        chk("ill_imem_req", 32'(bus.imem_req), 0);
        chk("ill_instret",  bus.instret,       0);
        do_reset();
        chk("ill_rst_trap",  32'(bus.trap),       0);
        chk("ill_rst_cause", 32'(bus.trap_cause), 0);

        // SYSTEM outranks JAL and halts for good.
        drive_instr(fb(I_SYS) | fb(I_JAL) | fb(I_RW), 1'b0, 0, 0, 1'b0);
        chk("sys_halted", 32'(bus.halted), 1);
        chk("sys_trap",   32'(bus.trap),   0);
        bus.imem_ready = 1'b1;
        repeat (5) @(negedge clk);
        chk("sys_imem_req", 32'(bus.imem_req), 0);
        chk("sys_ir_load",  32'(bus.ir_load),  0);
        chk("sys_pc_write", 32'(bus.pc_write), 0);
        do_reset();
        chk("sys_rst_halted", 32'(bus.halted), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
